// File: rtl/wshb_arb_pkg.sv
// Shared types for the two-master SDRAM Wishbone arbiter.
// Holds the grant state encoding, the priority-mode encodings and the pick rule.
package wshb_arb_pkg;

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} arb_state_t;

    localparam int PRIO_RR     = 0;
    localparam int PRIO_FIXED0 = 1;

    // On a tie, fixed mode always favours master 0; round-robin favours whoever was not served last.
    function automatic arb_state_t arb_pick(
        input logic req0,
        input logic req1,
        input logic last,
        input logic fixed0
    );
        arb_state_t pick;
        if (req0 && req1) begin
            pick = (fixed0 || last) ? GNT0 : GNT1;
        end else if (req0) begin
            pick = GNT0;
        end else if (req1) begin
            pick = GNT1;
        end else begin
            pick = IDLE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/wshb_if.sv
// Classic Wishbone bus bundle: request fields from the master, response fields from the slave.
// No storage; latency and backpressure are defined by whoever drives it.
interface wshb_if #(
    parameter int DATA_BYTES = 4
);
    logic                    cyc;
    logic                    stb;
    logic                    we;
    logic [31:0]             adr;
    logic [8*DATA_BYTES-1:0] dat_ms;
    logic [8*DATA_BYTES-1:0] dat_sm;
    logic [DATA_BYTES-1:0]   sel;
    logic [2:0]              cti;
    logic [1:0]              bte;
    logic                    ack;
    logic                    err;
    logic                    rty;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output dat_sm, ack, err, rty
    );
endinterface

// File: rtl/arb_ack_counter.sv
// Free-running acknowledge counter: +1 on each cycle inc is high, wraps at 2^CNT_W.
// Count is visible one cycle after the enabling cycle; never stalls anything.
module arb_ack_counter #(
    parameter int CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/wshb_arbiter.sv
// Shares the SDRAM Wishbone slave between the video reader (m0) and the writer (m1); 1-cycle registered grant.
// Request/response muxing is combinational off the grant; the loser sees no ack/err/rty and simply stalls.
module wshb_arbiter
    import wshb_arb_pkg::*;
#(
    parameter int PRIO_MODE = PRIO_RR,
    parameter int CNT_W     = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    wshb_if.slave            wshb_ifs0,
    wshb_if.slave            wshb_ifs1,
    wshb_if.master           wshb_ifm,
    output logic [1:0]       grant,
    output logic [CNT_W-1:0] ack_cnt0,
    output logic [CNT_W-1:0] ack_cnt1
);
    localparam logic FIXED0 = (PRIO_MODE == PRIO_FIXED0);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       last_q;
    logic       last_d;
    logic       req0;
    logic       req1;
    logic       gnt0;
    logic       gnt1;
    logic       ack0;
    logic       ack1;

    assign req0 = wshb_ifs0.cyc;
    assign req1 = wshb_ifs1.cyc;

    // The owner keeps the bus for its whole cycle; on release its own dropped cyc is already out of the vote.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GNT0: if (!req0) state_d = arb_pick(1'b0, req1, last_q, FIXED0);
            GNT1: if (!req1) state_d = arb_pick(req0, 1'b0, last_q, FIXED0);
            default: state_d = arb_pick(req0, req1, last_q, FIXED0);
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (state_d == GNT0 && state_q != GNT0) begin
            last_d = 1'b0;
        end
        if (state_d == GNT1 && state_q != GNT1) begin
            last_d = 1'b1;
        end
    end

    // last resets to 1 so master 0 takes the first round-robin tie.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    assign gnt0  = (state_q == GNT0);
    assign gnt1  = (state_q == GNT1);
    assign grant = {gnt1, gnt0};

    always_comb begin
        wshb_ifm.cyc    = 1'b0;
        wshb_ifm.stb    = 1'b0;
        wshb_ifm.we     = 1'b0;
        wshb_ifm.adr    = '0;
        wshb_ifm.dat_ms = '0;
        wshb_ifm.sel    = '0;
        wshb_ifm.cti    = '0;
        wshb_ifm.bte    = '0;
        if (gnt0) begin
            wshb_ifm.cyc    = wshb_ifs0.cyc;
            wshb_ifm.stb    = wshb_ifs0.stb;
            wshb_ifm.we     = wshb_ifs0.we;
            wshb_ifm.adr    = wshb_ifs0.adr;
            wshb_ifm.dat_ms = wshb_ifs0.dat_ms;
            wshb_ifm.sel    = wshb_ifs0.sel;
            wshb_ifm.cti    = wshb_ifs0.cti;
            wshb_ifm.bte    = wshb_ifs0.bte;
        end else if (gnt1) begin
            wshb_ifm.cyc    = wshb_ifs1.cyc;
            wshb_ifm.stb    = wshb_ifs1.stb;
            wshb_ifm.we     = wshb_ifs1.we;
            wshb_ifm.adr    = wshb_ifs1.adr;
            wshb_ifm.dat_ms = wshb_ifs1.dat_ms;
            wshb_ifm.sel    = wshb_ifs1.sel;
            wshb_ifm.cti    = wshb_ifs1.cti;
            wshb_ifm.bte    = wshb_ifs1.bte;
        end
    end

    // A response landing as the owner drops cyc belongs to no cycle, so it is neither forwarded nor counted.
    assign ack0 = gnt0 & req0 & wshb_ifm.ack;
    assign ack1 = gnt1 & req1 & wshb_ifm.ack;

    assign wshb_ifs0.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs1.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs0.ack    = ack0;
    assign wshb_ifs1.ack    = ack1;
    assign wshb_ifs0.err    = gnt0 & req0 & wshb_ifm.err;
    assign wshb_ifs1.err    = gnt1 & req1 & wshb_ifm.err;
    assign wshb_ifs0.rty    = gnt0 & req0 & wshb_ifm.rty;
    assign wshb_ifs1.rty    = gnt1 & req1 & wshb_ifm.rty;

    arb_ack_counter #(.CNT_W(CNT_W)) u_cnt0 (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .inc     (ack0),
        .cnt     (ack_cnt0)
    );

    arb_ack_counter #(.CNT_W(CNT_W)) u_cnt1 (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .inc     (ack1),
        .cnt     (ack_cnt1)
    );

endmodule

// File: tb/tb_wshb_arbiter.sv
// Bench for wshb_arbiter: DUT a is round-robin with 4-bit counters, DUT b is fixed-priority with 16-bit counters.
// Expected grants, forwarding and counts come from a cycle-level ownership model driven by the arbitration rules.
`timescale 1ns/1ps
module tb_wshb_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [2];
    logic        m_cyc [2][2];
    logic        m_stb [2][2];
    logic        m_we  [2][2];
    logic [31:0] m_adr [2][2];
    logic [31:0] m_dat [2][2];
    logic [3:0]  m_sel [2][2];
    logic [2:0]  m_cti [2][2];
    logic [1:0]  m_bte [2][2];
    logic        s_ack [2];
    logic        s_err [2];
    logic        s_rty [2];
    logic [31:0] s_dat [2];

    logic        o_cyc [2];
    logic        o_stb [2];
    logic        o_we  [2];
    logic [31:0] o_adr [2];
    logic [31:0] o_dat [2];
    logic [3:0]  o_sel [2];
    logic [2:0]  o_cti [2];
    logic [1:0]  o_bte [2];
    logic        o_ack [2][2];
    logic        o_err [2][2];
    logic        o_rty [2][2];
    logic [31:0] o_dsm [2][2];
    logic [1:0]  o_gnt [2];
    logic [15:0] o_cnt [2][2];

    logic [3:0]  cnt_a0, cnt_a1;
    logic [15:0] cnt_b0, cnt_b1;

    int vecs;
    int errs;
    int g_seq[$];
    int g_done[2];
    logic [31:0] g_adr1[$];

    wshb_if #(.DATA_BYTES(4)) ia0 ();
    wshb_if #(.DATA_BYTES(4)) ia1 ();
    wshb_if #(.DATA_BYTES(4)) iam ();
    wshb_if #(.DATA_BYTES(4)) ib0 ();
    wshb_if #(.DATA_BYTES(4)) ib1 ();
    wshb_if #(.DATA_BYTES(4)) ibm ();

`define TB_HOOK(D, S0, S1, M) \
    assign S0.cyc = m_cyc[D][0]; assign S0.stb = m_stb[D][0]; assign S0.we = m_we[D][0]; \
    assign S0.adr = m_adr[D][0]; assign S0.dat_ms = m_dat[D][0]; assign S0.sel = m_sel[D][0]; \
    assign S0.cti = m_cti[D][0]; assign S0.bte = m_bte[D][0]; \
    assign S1.cyc = m_cyc[D][1]; assign S1.stb = m_stb[D][1]; assign S1.we = m_we[D][1]; \
    assign S1.adr = m_adr[D][1]; assign S1.dat_ms = m_dat[D][1]; assign S1.sel = m_sel[D][1]; \
    assign S1.cti = m_cti[D][1]; assign S1.bte = m_bte[D][1]; \
    assign M.ack = s_ack[D]; assign M.err = s_err[D]; assign M.rty = s_rty[D]; assign M.dat_sm = s_dat[D]; \
    assign o_cyc[D] = M.cyc; assign o_stb[D] = M.stb; assign o_we[D] = M.we; assign o_adr[D] = M.adr; \
    assign o_dat[D] = M.dat_ms; assign o_sel[D] = M.sel; assign o_cti[D] = M.cti; assign o_bte[D] = M.bte; \
    assign o_ack[D][0] = S0.ack; assign o_err[D][0] = S0.err; assign o_rty[D][0] = S0.rty; assign o_dsm[D][0] = S0.dat_sm; \
    assign o_ack[D][1] = S1.ack; assign o_err[D][1] = S1.err; assign o_rty[D][1] = S1.rty; assign o_dsm[D][1] = S1.dat_sm;

    `TB_HOOK(0, ia0, ia1, iam)
    `TB_HOOK(1, ib0, ib1, ibm)

    assign o_cnt[0][0] = {12'b0, cnt_a0};
    assign o_cnt[0][1] = {12'b0, cnt_a1};
    assign o_cnt[1][0] = cnt_b0;
    assign o_cnt[1][1] = cnt_b1;

    wshb_arbiter #(.PRIO_MODE(0), .CNT_W(4)) dut_a (
        .sys_clk   (clk),
        .sys_rst   (rst[0]),
        .wshb_ifs0 (ia0),
        .wshb_ifs1 (ia1),
        .wshb_ifm  (iam),
        .grant     (o_gnt[0]),
        .ack_cnt0  (cnt_a0),
        .ack_cnt1  (cnt_a1)
    );

    wshb_arbiter #(.PRIO_MODE(1), .CNT_W(16)) dut_b (
        .sys_clk   (clk),
        .sys_rst   (rst[1]),
        .wshb_ifs0 (ib0),
        .wshb_ifs1 (ib1),
        .wshb_ifm  (ibm),
        .grant     (o_gnt[1]),
        .ack_cnt0  (cnt_b0),
        .ack_cnt1  (cnt_b1)
    );

    task automatic clear_inputs(input int d);
        for (int i = 0; i < 2; i++) begin
            m_cyc[d][i] = 1'b0; m_stb[d][i] = 1'b0; m_we[d][i] = 1'b0;
            m_adr[d][i] = '0;   m_dat[d][i] = '0;   m_sel[d][i] = '0;
            m_cti[d][i] = '0;   m_bte[d][i] = '0;
        end
        s_ack[d] = 1'b0; s_err[d] = 1'b0; s_rty[d] = 1'b0; s_dat[d] = '0;
    endtask

    task automatic do_reset(input int d);
        clear_inputs(d);
        @(negedge clk); rst[d] = 1'b1;
        @(negedge clk); rst[d] = 1'b0;
        g_seq.delete();
        g_adr1.delete();
        g_done[0] = 0;
        g_done[1] = 0;
    endtask

    // Cycle-level traffic: masters issue bursts, a random slave responds, and the ownership model predicts every output.
    task automatic test_traffic(input int d, input int maxcyc, input int lim0, input int lim1,
                                input int blen, input int gapmax, input bit ack_alt, input logic [31:0] base);
        int owner, last, nxt;
        int rem[2], gap[2], bursts[2], mcnt[2], lim[2];
        int mask;
        bit fin, fixed;
        logic exp_ack[2];
        logic [1:0] eg;
        logic [2:0] exp_rsp;
        logic [75:0] fw_exp, fw_obs;
        owner = -1; last = 1; fin = 1'b0; fixed = (d == 1);
        mask = (d == 0) ? 15 : 65535;
        lim[0] = lim0; lim[1] = lim1;
        for (int i = 0; i < 2; i++) begin
            rem[i] = 0; gap[i] = 0; bursts[i] = 0; mcnt[i] = 0; exp_ack[i] = 1'b0;
        end
        @(posedge clk); #1;
        for (int c = 0; c < maxcyc; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (rem[i] == 0) begin
                    if (gap[i] > 0) begin
                        gap[i]--;
                    end else if (bursts[i] < lim[i] && (blen != 0 || $urandom_range(1) == 1)) begin
                        rem[i] = (blen != 0) ? blen : int'($urandom_range(4, 1));
                        bursts[i]++;
                        m_cyc[d][i] = 1'b1;
                        m_stb[d][i] = 1'b1;
                        m_we[d][i]  = (base != 0) ? 1'b1 : 1'($urandom_range(1));
                        m_adr[d][i] = (base != 0) ? base : (32'($urandom()) & 32'hFFFF_FFFC);
                        m_dat[d][i] = 32'($urandom());
                        m_sel[d][i] = 4'($urandom_range(15, 1));
                        m_cti[d][i] = 3'($urandom_range(7));
                        m_bte[d][i] = 2'($urandom_range(3));
                    end
                end
            end
            s_ack[d] = ack_alt ? ((c % 2) == 1) : 1'($urandom_range(1));
            s_err[d] = 1'($urandom_range(1));
            s_rty[d] = 1'($urandom_range(1));
            s_dat[d] = 32'($urandom());
            @(negedge clk);
            eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
            vecs++;
            if (o_gnt[d] !== eg) begin
                errs++;
                $display("FAIL grant dut%0d cyc%0d: got %b want %b", d, c, o_gnt[d], eg);
            end
            fw_obs = {o_cyc[d], o_stb[d], o_we[d], o_adr[d], o_dat[d], o_sel[d], o_cti[d], o_bte[d]};
            fw_exp = '0;
            if (owner >= 0) begin
                fw_exp = {m_cyc[d][owner], m_stb[d][owner], m_we[d][owner], m_adr[d][owner],
                          m_dat[d][owner], m_sel[d][owner], m_cti[d][owner], m_bte[d][owner]};
            end
            vecs++;
            if (fw_obs !== fw_exp) begin
                errs++;
                $display("FAIL forward dut%0d cyc%0d: got %h want %h", d, c, fw_obs, fw_exp);
            end
            for (int i = 0; i < 2; i++) begin
                exp_ack[i] = (owner == i) && m_cyc[d][i] && s_ack[d];
                exp_rsp = {exp_ack[i], (owner == i) && m_cyc[d][i] && s_err[d],
                           (owner == i) && m_cyc[d][i] && s_rty[d]};
                vecs++;
                if ({o_ack[d][i], o_err[d][i], o_rty[d][i]} !== exp_rsp) begin
                    errs++;
                    $display("FAIL response dut%0d m%0d cyc%0d: got %b want %b", d, i, c,
                             {o_ack[d][i], o_err[d][i], o_rty[d][i]}, exp_rsp);
                end
                vecs++;
                if (o_dsm[d][i] !== s_dat[d]) begin
                    errs++;
                    $display("FAIL dat_sm dut%0d m%0d cyc%0d: got %h want %h", d, i, c, o_dsm[d][i], s_dat[d]);
                end
                vecs++;
                if (o_cnt[d][i] !== 16'(mcnt[i])) begin
                    errs++;
                    $display("FAIL ack_cnt dut%0d m%0d cyc%0d: got %0d want %0d", d, i, c, o_cnt[d][i], mcnt[i]);
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (exp_ack[i]) begin
                    mcnt[i] = (mcnt[i] + 1) & mask;
                    rem[i]--;
                    g_done[i]++;
                    if (i == 1) g_adr1.push_back(m_adr[d][1]);
                end
            end
            if (owner >= 0 && m_cyc[d][owner]) begin
                nxt = owner;
            end else if (m_cyc[d][0] && m_cyc[d][1]) begin
                nxt = (fixed || last == 1) ? 0 : 1;
            end else if (m_cyc[d][0]) begin
                nxt = 0;
            end else if (m_cyc[d][1]) begin
                nxt = 1;
            end else begin
                nxt = -1;
            end
            if (nxt >= 0 && nxt != owner) begin
                last = nxt;
                g_seq.push_back(nxt);
            end
            owner = nxt;
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (exp_ack[i]) begin
                    if (rem[i] == 0) begin
                        m_cyc[d][i] = 1'b0;
                        m_stb[d][i] = 1'b0;
                        gap[i] = int'($urandom_range(gapmax, 1));
                    end else begin
                        m_adr[d][i] = m_adr[d][i] + 32'd4;
                        m_dat[d][i] = 32'($urandom());
                    end
                end
            end
            if (bursts[0] >= lim[0] && bursts[1] >= lim[1] && rem[0] == 0 && rem[1] == 0 && owner < 0) begin
                fin = 1'b1;
                break;
            end
        end
        vecs++;
        if (!fin) begin
            errs++;
            $display("FAIL traffic_timeout dut%0d: got unfinished want done within %0d cycles", d, maxcyc);
        end
        clear_inputs(d);
    endtask

    task automatic test_reset(input int d);
        clear_inputs(d);
        m_cyc[d][0] = 1'b1; m_stb[d][0] = 1'b1; m_adr[d][0] = 32'h40;
        m_cyc[d][1] = 1'b1; m_stb[d][1] = 1'b1; m_adr[d][1] = 32'h80;
        @(negedge clk); rst[d] = 1'b1; #1;
        vecs++; if (o_cyc[d] !== 1'b0) begin errs++; $display("FAIL reset_cyc dut%0d: got %b want 0", d, o_cyc[d]); end
        vecs++; if (o_gnt[d] !== 2'b00) begin errs++; $display("FAIL reset_grant dut%0d: got %b want 00", d, o_gnt[d]); end
        vecs++; if (o_cnt[d][0] !== 16'd0 || o_cnt[d][1] !== 16'd0) begin
            errs++; $display("FAIL reset_cnt dut%0d: got %0d/%0d want 0/0", d, o_cnt[d][0], o_cnt[d][1]);
        end
        @(posedge clk); #1;
        vecs++; if (o_gnt[d] !== 2'b00 || o_cyc[d] !== 1'b0) begin
            errs++; $display("FAIL reset_hold dut%0d: got gnt %b cyc %b want 00 0", d, o_gnt[d], o_cyc[d]);
        end
        @(negedge clk); rst[d] = 1'b0; #1;
        vecs++; if (o_gnt[d] !== 2'b00) begin errs++; $display("FAIL release_grant dut%0d: got %b want 00", d, o_gnt[d]); end
        @(posedge clk); #1;
        vecs++; if (o_gnt[d] !== 2'b01 || o_adr[d] !== 32'h40) begin
            errs++; $display("FAIL first_grant dut%0d: got %b adr %h want 01 adr 40", d, o_gnt[d], o_adr[d]);
        end
        @(posedge clk); #1;
        vecs++; if (o_gnt[d] !== 2'b01) begin errs++; $display("FAIL hold_grant dut%0d: got %b want 01", d, o_gnt[d]); end
        clear_inputs(d);
    endtask

    task automatic test_single_master();
        do_reset(0);
        test_traffic(0, 200, 0, 1, 4, 1, 1'b1, 32'h10);
        vecs++; if (g_done[1] !== 4 || g_done[0] !== 0) begin
            errs++; $display("FAIL single_count: got %0d/%0d want 0/4", g_done[0], g_done[1]);
        end
        vecs++; if (o_cnt[0][1] !== 16'd4 || o_cnt[0][0] !== 16'd0) begin
            errs++; $display("FAIL single_ack_cnt: got %0d/%0d want 0/4", o_cnt[0][0], o_cnt[0][1]);
        end
        for (int k = 0; k < 4; k++) begin
            vecs++;
            if (k >= g_adr1.size() || g_adr1[k] !== 32'h10 + 32'(4 * k)) begin
                errs++; $display("FAIL single_adr%0d: got %h want %h", k,
                                 (k < g_adr1.size()) ? g_adr1[k] : 32'hx, 32'h10 + 32'(4 * k));
            end
        end
    endtask

    task automatic test_rr_contention();
        do_reset(0);
        test_traffic(0, 400, 3, 3, 3, 1, 1'b0, 32'h0);
        vecs++; if (g_seq.size() !== 6) begin errs++; $display("FAIL rr_grants: got %0d want 6", g_seq.size()); end
        for (int k = 0; k < g_seq.size(); k++) begin
            vecs++;
            if (g_seq[k] !== (k % 2)) begin errs++; $display("FAIL rr_order%0d: got m%0d want m%0d", k, g_seq[k], k % 2); end
        end
        vecs++; if (o_cnt[0][0] !== 16'd9 || o_cnt[0][1] !== 16'd9) begin
            errs++; $display("FAIL rr_ack_cnt: got %0d/%0d want 9/9", o_cnt[0][0], o_cnt[0][1]);
        end
    endtask

    task automatic test_fixed_contention();
        do_reset(1);
        test_traffic(1, 400, 3, 3, 3, 1, 1'b0, 32'h0);
        vecs++; if (g_seq.size() < 1 || g_seq[0] !== 0) begin
            errs++; $display("FAIL fixed_first: got %0d want m0", (g_seq.size() > 0) ? g_seq[0] : -1);
        end
        vecs++; if (o_cnt[1][0] !== 16'd9 || o_cnt[1][1] !== 16'd9) begin
            errs++; $display("FAIL fixed_ack_cnt: got %0d/%0d want 9/9", o_cnt[1][0], o_cnt[1][1]);
        end
    endtask

    task automatic test_midburst_reset();
        do_reset(0);
        m_cyc[0][0] = 1'b1; m_stb[0][0] = 1'b1; m_adr[0][0] = 32'h100;
        m_dat[0][0] = 32'h1111_0000; m_sel[0][0] = 4'hF;
        s_ack[0] = 1'b1; s_dat[0] = 32'hCAFE_0001;
        @(posedge clk); #1;
        vecs++; if (o_gnt[0] !== 2'b01) begin errs++; $display("FAIL mid_grant: got %b want 01", o_gnt[0]); end
        @(posedge clk); #1;
        m_adr[0][0] = 32'h104;
        vecs++; if (o_cnt[0][0] !== 16'd1) begin errs++; $display("FAIL mid_cnt_pre: got %0d want 1", o_cnt[0][0]); end
        vecs++; if (o_ack[0][0] !== 1'b1) begin errs++; $display("FAIL mid_ack2: got %b want 1", o_ack[0][0]); end
        @(negedge clk); rst[0] = 1'b1; #1;
        vecs++; if (o_cyc[0] !== 1'b0 || o_stb[0] !== 1'b0) begin
            errs++; $display("FAIL mid_cyc: got %b%b want 00", o_cyc[0], o_stb[0]);
        end
        vecs++; if (o_gnt[0] !== 2'b00 || o_cnt[0][0] !== 16'd0 || o_ack[0][0] !== 1'b0) begin
            errs++; $display("FAIL mid_clear: got gnt %b cnt %0d ack %b want 00 0 0", o_gnt[0], o_cnt[0][0], o_ack[0][0]);
        end
        clear_inputs(0);
        @(negedge clk); rst[0] = 1'b0;
        g_seq.delete(); g_adr1.delete(); g_done[0] = 0; g_done[1] = 0;
        test_traffic(0, 600, 3, 3, 0, 2, 1'b0, 32'h0);
    endtask

    task automatic test_counter_wrap();
        do_reset(0);
        test_traffic(0, 400, 17, 0, 1, 1, 1'b0, 32'h0);
        vecs++; if (g_done[0] !== 17) begin errs++; $display("FAIL wrap_accesses: got %0d want 17", g_done[0]); end
        vecs++; if (o_cnt[0][0] !== 16'd1) begin errs++; $display("FAIL wrap_cnt: got %0d want 1", o_cnt[0][0]); end
    endtask

    task automatic test_random(input int d);
        do_reset(d);
        test_traffic(d, 4000, 40, 40, 0, 3, 1'b0, 32'h0);
        vecs++; if (o_cnt[d][0] !== 16'(g_done[0] & ((d == 0) ? 15 : 65535))) begin
            errs++; $display("FAIL random_cnt0 dut%0d: got %0d want %0d", d, o_cnt[d][0], g_done[0]);
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            clear_inputs(d);
        end
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        test_reset(0);
        test_reset(1);
        test_single_master();
        test_rr_contention();
        test_fixed_contention();
        test_midburst_reset();
        test_counter_wrap();
        test_random(0);
        test_random(1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
